// File: rtl/icosoc_irq_arbiter.sv
// icosoc_irq_arbiter
//   Latches one-cycle IRQ pulses from up to NUM_SRC peripherals as pending bits,
//   arbitrates the enabled ones onto a single CPU interrupt line and holds that
//   line, with the winning source ID, until software writes end-of-interrupt.
//   Register access uses the icosoc ctrl bus (one-cycle ctrl_done handshake).
//
//   Optional feature macro: ICOSOC_IRQARB_RR_EN
//     defined   -> CONFIG bit1 (rr_mode) selects round-robin arbitration that
//                  starts scanning at the source after the last one serviced.
//     undefined -> fixed priority only (lowest index wins), CONFIG bit1 reads 0.
module icosoc_irq_arbiter #(
  parameter int NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               ctrl_wr,
  input  logic               ctrl_rd,
  input  logic [7:0]         ctrl_addr,
  input  logic [31:0]        ctrl_wdat,
  output logic [31:0]        ctrl_rdat,
  output logic               ctrl_done,
  input  logic [NUM_SRC-1:0] src_irq,
  output logic               cpu_irq,
  output logic [3:0]         cpu_irq_id
);

  // Register byte addresses
  localparam logic [7:0] ADDR_PENDING = 8'h00;
  localparam logic [7:0] ADDR_ENABLE  = 8'h04;
  localparam logic [7:0] ADDR_VECTOR  = 8'h08;
  localparam logic [7:0] ADDR_CONFIG  = 8'h0C;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic               gen_en_q, gen_en_d;
  logic               rr_mode;
  logic [3:0]         cur_id_q, cur_id_d;
  logic               ctrl_done_q, ctrl_done_d;
  logic [31:0]        ctrl_rdat_q, ctrl_rdat_d;

`ifdef ICOSOC_IRQARB_RR_EN
  logic               rr_mode_q, rr_mode_d;
  logic [3:0]         rr_ptr_q, rr_ptr_d;
`endif

  // Bus decode
  logic               accept;
  logic               wr_acc;
  logic               rd_acc;
  logic               sel_pending;
  logic               sel_enable;
  logic               sel_vector;
  logic               sel_config;

  // Arbitration / service control
  logic [NUM_SRC-1:0] cand;
  logic [3:0]         win_id;
  logic               start;
  logic               eoi;
  logic [3:0]         next_ptr;

  // Only the low bits of write data are meaningful; fold the rest into a sink.
  logic               unused_wdat;
  assign unused_wdat = ^ctrl_wdat;

  assign accept      = (ctrl_wr | ctrl_rd) && !ctrl_done_q;
  assign wr_acc      = accept && ctrl_wr;
  assign rd_acc      = accept && ctrl_rd;
  assign sel_pending = (ctrl_addr == ADDR_PENDING);
  assign sel_enable  = (ctrl_addr == ADDR_ENABLE);
  assign sel_vector  = (ctrl_addr == ADDR_VECTOR);
  assign sel_config  = (ctrl_addr == ADDR_CONFIG);

  assign cand  = pending_q & enable_q;
  assign start = (state_q == IDLE) && gen_en_q && (cand != '0);
  // A VECTOR write only means EOI while a source is in service.
  assign eoi   = wr_acc && sel_vector && (state_q == SERVE);

  // Pointer for round-robin: source after the one just serviced, wrapping.
  assign next_ptr = (cur_id_q == 4'(NUM_SRC - 1)) ? 4'd0 : cur_id_q + 4'd1;

`ifdef ICOSOC_IRQARB_RR_EN
  assign rr_mode = rr_mode_q;
`else
  assign rr_mode = 1'b0;
`endif

  // Winner selection: lowest set candidate, or first set at/after rr_ptr.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    win_id = 4'd0;
    if (!rr_mode) begin
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
        if (cand[i]) win_id = 4'(i);
      end
    end
`ifdef ICOSOC_IRQARB_RR_EN
    else begin
      logic found;
      int   idx;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < NUM_SRC; k++) begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= NUM_SRC) idx = idx - NUM_SRC;
        if (!found && cand[idx]) begin
          found  = 1'b1;
          win_id = 4'(idx);
        end
      end
    end
`endif
  end

  // Pending bits: W1C and EOI clear, new pulses set; a set in the same cycle wins.
  always_comb begin
    logic [NUM_SRC-1:0] clr;
    clr = '0;
    if (wr_acc && sel_pending) clr = ctrl_wdat[NUM_SRC-1:0];
    for (int i = 0; i < NUM_SRC; i++) begin
      if (eoi && (cur_id_q == 4'(i))) clr[i] = 1'b1;
    end
    pending_d = (pending_q & ~clr) | src_irq;
  end

  // Configuration registers, service ID capture and round-robin pointer.
  always_comb begin
    enable_d = enable_q;
    gen_en_d = gen_en_q;
    cur_id_d = cur_id_q;
`ifdef ICOSOC_IRQARB_RR_EN
    rr_mode_d = rr_mode_q;
    rr_ptr_d  = rr_ptr_q;
`endif
    if (wr_acc && sel_enable) enable_d = ctrl_wdat[NUM_SRC-1:0];
    if (wr_acc && sel_config) begin
      gen_en_d = ctrl_wdat[0];
`ifdef ICOSOC_IRQARB_RR_EN
      rr_mode_d = ctrl_wdat[1];
`endif
    end
    if (start) cur_id_d = win_id;
`ifdef ICOSOC_IRQARB_RR_EN
    if (eoi) rr_ptr_d = next_ptr;
`endif
  end

  // Bus response: one-cycle done pulse with registered read data.
  always_comb begin
    ctrl_done_d = accept;
    ctrl_rdat_d = 32'd0;
    if (rd_acc) begin
      unique case (1'b1)
        sel_pending: ctrl_rdat_d = 32'(pending_q);
        sel_enable:  ctrl_rdat_d = 32'(enable_q);
        sel_vector:  ctrl_rdat_d = {(state_q == SERVE), 27'd0, cur_id_q};
        sel_config:  ctrl_rdat_d = {30'd0, rr_mode, gen_en_q};
        default:     ctrl_rdat_d = 32'd0;
      endcase
    end
  end

  // FSM next state: arbitrate in IDLE, leave SERVE only on EOI.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SERVE;
      SERVE:   if (eoi)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: line and ID are driven straight from state, so they are glitch-free.
  always_comb begin
    cpu_irq    = 1'b0;
    cpu_irq_id = 4'd0;
    if (state_q == SERVE) begin
      cpu_irq    = 1'b1;
      cpu_irq_id = cur_id_q;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so all registers update from pre-edge values.
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pending_q   <= '0;
      enable_q    <= '0;
      gen_en_q    <= 1'b0;
      cur_id_q    <= 4'd0;
      ctrl_done_q <= 1'b0;
      ctrl_rdat_q <= 32'd0;
    end else begin
      pending_q   <= pending_d;
      enable_q    <= enable_d;
      gen_en_q    <= gen_en_d;
      cur_id_q    <= cur_id_d;
      ctrl_done_q <= ctrl_done_d;
      ctrl_rdat_q <= ctrl_rdat_d;
    end
  end

`ifdef ICOSOC_IRQARB_RR_EN
  // Round-robin mode bit and pointer.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rr_mode_q <= 1'b0;
      rr_ptr_q  <= 4'd0;
    end else begin
      rr_mode_q <= rr_mode_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end
`endif

  assign ctrl_done = ctrl_done_q;
  assign ctrl_rdat = ctrl_rdat_q;

endmodule

// File: tb/tb_icosoc_irq_arbiter.sv
// Testbench for icosoc_irq_arbiter: directed vectors, expected read data and
// expected interrupt IDs are queued by the stimulus and consumed by monitors.
module tb_icosoc_irq_arbiter;

  localparam int NUM_SRC = 8;

  logic               clk = 1'b0;
  logic               resetn;
  logic               ctrl_wr;
  logic               ctrl_rd;
  logic [7:0]         ctrl_addr;
  logic [31:0]        ctrl_wdat;
  logic [31:0]        ctrl_rdat;
  logic               ctrl_done;
  logic [NUM_SRC-1:0] src_irq;
  logic               cpu_irq;
  logic [3:0]         cpu_irq_id;

  int checks = 0;
  int errors = 0;

  logic [31:0] rd_q[$];
  logic [3:0]  irq_q[$];
  logic        acc_is_rd = 1'b0;
  logic        irq_prev  = 1'b0;
  logic        done_prev = 1'b0;

  icosoc_irq_arbiter #(.NUM_SRC(NUM_SRC)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .ctrl_wr    (ctrl_wr),
    .ctrl_rd    (ctrl_rd),
    .ctrl_addr  (ctrl_addr),
    .ctrl_wdat  (ctrl_wdat),
    .ctrl_rdat  (ctrl_rdat),
    .ctrl_done  (ctrl_done),
    .src_irq    (src_irq),
    .cpu_irq    (cpu_irq),
    .cpu_irq_id (cpu_irq_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [31:0] d,
                        input logic [NUM_SRC-1:0] pulse = '0);
    ctrl_wr   = 1'b1;
    ctrl_addr = a;
    ctrl_wdat = d;
    src_irq   = pulse;
    tick();
    ctrl_wr   = 1'b0;
    src_irq   = '0;
    tick();
  endtask

  task automatic bus_rd(input logic [7:0] a, input logic [31:0] exp);
    rd_q.push_back(exp);
    acc_is_rd = 1'b1;
    ctrl_rd   = 1'b1;
    ctrl_addr = a;
    tick();
    ctrl_rd   = 1'b0;
    tick();
    acc_is_rd = 1'b0;
  endtask

  task automatic pulse(input logic [NUM_SRC-1:0] m);
    src_irq = m;
    tick();
    src_irq = '0;
  endtask

  // Read-data monitor: every completed read pops one expected value.
  always @(negedge clk) begin
    if (ctrl_done === 1'b1) begin
      check("done_one_cycle", {31'd0, done_prev}, 32'd0);
      if (acc_is_rd) begin
        if (rd_q.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
        else                  check("rd_data", ctrl_rdat, rd_q.pop_front());
      end
    end
    done_prev <= (ctrl_done === 1'b1);
  end

  // Interrupt monitor: every rising cpu_irq pops one expected source ID.
  always @(negedge clk) begin
    if (cpu_irq === 1'b1 && !irq_prev) begin
      if (irq_q.size() == 0) check("irq_unexpected", 32'd1, 32'd0);
      else                   check("irq_id", 32'(cpu_irq_id), 32'(irq_q.pop_front()));
    end
    irq_prev <= (cpu_irq === 1'b1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn    = 1'b0;
    ctrl_wr   = 1'b0;
    ctrl_rd   = 1'b0;
    ctrl_addr = 8'h00;
    ctrl_wdat = 32'd0;
    src_irq   = '0;
    repeat (3) tick();

    // T1 reset state
    check("rst_cpu_irq", {31'd0, cpu_irq}, 32'd0);
    check("rst_irq_id", 32'(cpu_irq_id), 32'd0);
    check("rst_done", {31'd0, ctrl_done}, 32'd0);
    check("rst_rdat", ctrl_rdat, 32'd0);
    resetn = 1'b1;
    tick();
    bus_rd(8'h00, 32'd0);
    bus_rd(8'h04, 32'd0);
    bus_rd(8'h08, 32'd0);
    bus_rd(8'h0C, 32'd0);
    bus_rd(8'h10, 32'd0);

    // Enable bits above NUM_SRC read back as zero
    bus_wr(8'h04, 32'hFFFF_FFFF);
    bus_rd(8'h04, 32'h0000_00FF);

    // T2 fixed priority, two-edge latency, EOI hand-over
    bus_wr(8'h04, 32'h05);
    bus_wr(8'h0C, 32'h01);
    irq_q.push_back(4'd0);
    pulse(8'h05);
    check("irq_early", {31'd0, cpu_irq}, 32'd0);
    tick();
    check("irq_latency", {31'd0, cpu_irq}, 32'd1);
    bus_rd(8'h08, 32'h8000_0000);
    irq_q.push_back(4'd2);
    bus_wr(8'h08, 32'd0);
    bus_rd(8'h08, 32'h8000_0002);
    bus_wr(8'h08, 32'd0);
    check("eoi_idle", {31'd0, cpu_irq}, 32'd0);
    bus_rd(8'h00, 32'd0);
    // EOI while idle just completes
    bus_wr(8'h08, 32'd0);
    check("eoi_in_idle", {31'd0, cpu_irq}, 32'd0);

    // T3 mask
    bus_wr(8'h04, 32'h00);
    pulse(8'h02);
    repeat (3) tick();
    check("masked_no_irq", {31'd0, cpu_irq}, 32'd0);
    bus_rd(8'h00, 32'h02);
    irq_q.push_back(4'd1);
    bus_wr(8'h04, 32'h02);
    bus_rd(8'h08, 32'h8000_0001);
    // W1C of the in-service bit clears it but keeps service
    bus_wr(8'h00, 32'h02);
    bus_rd(8'h00, 32'h00);
    check("w1c_keeps_service", {31'd0, cpu_irq}, 32'd1);
    bus_wr(8'h08, 32'd0);
    check("eoi_drop", {31'd0, cpu_irq}, 32'd0);

    // T4 set wins over W1C in the same cycle
    bus_wr(8'h04, 32'h00);
    bus_wr(8'h00, 32'h02, 8'h02);
    bus_rd(8'h00, 32'h02);
    bus_wr(8'h00, 32'h02);
    bus_rd(8'h00, 32'h00);

    // T5 round-robin (ids 0,1,0,1) or fixed priority (ids 0,0,0,0)
    bus_wr(8'h04, 32'h03);
`ifdef ICOSOC_IRQARB_RR_EN
    bus_wr(8'h0C, 32'h03);
    bus_rd(8'h0C, 32'h03);
`else
    bus_wr(8'h0C, 32'h03);
    bus_rd(8'h0C, 32'h01);
`endif
    irq_q.push_back(4'd0);
    pulse(8'h03);
    tick();
    for (int n = 0; n < 3; n++) begin
`ifdef ICOSOC_IRQARB_RR_EN
      irq_q.push_back((n % 2 == 0) ? 4'd1 : 4'd0);
`else
      irq_q.push_back(4'd0);
`endif
      bus_wr(8'h08, 32'd0, 8'h03);
    end
    bus_wr(8'h0C, 32'h00);
    bus_wr(8'h08, 32'd0);
    check("rr_final_idle", {31'd0, cpu_irq}, 32'd0);
    bus_wr(8'h00, 32'hFF);
    bus_rd(8'h00, 32'h00);

    // T6 reset while in service
    bus_wr(8'h04, 32'h01);
    bus_wr(8'h0C, 32'h01);
    irq_q.push_back(4'd0);
    pulse(8'h01);
    tick();
    check("t6_irq_up", {31'd0, cpu_irq}, 32'd1);
    pulse(8'h01);
    resetn = 1'b0;
    tick();
    check("t6_irq_drop", {31'd0, cpu_irq}, 32'd0);
    check("t6_irq_id", 32'(cpu_irq_id), 32'd0);
    resetn = 1'b1;
    tick();
    bus_rd(8'h00, 32'd0);
    bus_rd(8'h04, 32'd0);
    bus_rd(8'h0C, 32'd0);

    repeat (5) tick();
    check("rd_q_drained", 32'(rd_q.size()), 32'd0);
    check("irq_q_drained", 32'(irq_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
